// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package lsu_pkg;

    // Access size codes carried in funct3[1:0]
    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;

    // Writeback result source selects
    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data bus: byte enables, replicated store data,
// shifted and extended load data, and misalignment detection.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]              i_funct3,
    input  logic [1:0]              i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic [3:0]              o_be,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata_ext,
    output logic                    o_misaligned
);

    logic [DATA_WIDTH-1:0] w_rdata_shift;
    logic                  w_unsigned;

    // Addressed byte moves down to lane 0 before extension
    assign w_rdata_shift = i_rdata >> {i_addr, 3'b000};
    assign w_unsigned    = i_funct3[2];

    // Decode size into enables, store replication and load extension
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = '0;
        o_rdata_ext  = '0;
        o_misaligned = 1'b0;
        case (i_funct3[1:0])
            LSU_B: begin
                o_be        = 4'b0001 << i_addr;
                o_wdata     = {(DATA_WIDTH/8){i_wdata[7:0]}};
                o_rdata_ext = w_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_rdata_shift[7:0]}
                                         : {{(DATA_WIDTH-8){w_rdata_shift[7]}},
                                            w_rdata_shift[7:0]};
            end
            LSU_H: begin
                o_be         = 4'b0011 << i_addr;
                o_wdata      = {(DATA_WIDTH/16){i_wdata[15:0]}};
                o_rdata_ext  = w_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_rdata_shift[15:0]}
                                          : {{(DATA_WIDTH-16){w_rdata_shift[15]}},
                                             w_rdata_shift[15:0]};
                o_misaligned = i_addr[0];
            end
            LSU_W: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_rdata_ext  = w_rdata_shift;
                o_misaligned = (i_addr != 2'b00);
            end
            default: begin
                // Size 11 is not a legal RV32 access
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: issues loads/stores on the req/ack data bus, holds EX/MEM while an
// access is outstanding, and registers results toward MEM/WB.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_THREADS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reg_write_m_i,
    input  logic                     mem_write_m_i,
    input  logic [1:0]               result_src_m_i,
    input  logic [2:0]               funct3_m_i,
    input  logic [DATA_WIDTH-1:0]    alu_result_m_i,
    input  logic [DATA_WIDTH-1:0]    write_data_m_i,
    input  logic [4:0]               rd_m_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m_i,
    input  logic [BITS_THREADS-1:0]  tid_m_i,
    output logic                     stall_m_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]               dmem_be_o,
    output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
    input  logic                     dmem_ack_i,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
    output logic                     reg_write_w_o,
    output logic [1:0]               result_src_w_o,
    output logic [DATA_WIDTH-1:0]    read_data_w_o,
    output logic [DATA_WIDTH-1:0]    alu_result_w_o,
    output logic [4:0]               rd_w_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_w_o,
    output logic [BITS_THREADS-1:0]  tid_w_o,
    output logic                     misalign_o,
    output logic                     bus_err_o,
    output logic [BITS_THREADS-1:0]  err_tid_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    // Hold registers for the access in flight
    logic                     r_h_we;
    logic [2:0]               r_h_funct3;
    logic [DATA_WIDTH-1:0]    r_h_alu;
    logic [DATA_WIDTH-1:0]    r_h_wdata;
    logic                     r_h_reg_write;
    logic [1:0]               r_h_result_src;
    logic [4:0]               r_h_rd;
    logic [ADDRESS_WIDTH-1:0] r_h_pc4;
    logic [BITS_THREADS-1:0]  r_h_tid;

    // Next values for the MEM/WB output registers
    logic                     w_wb_reg_write;
    logic [1:0]               w_wb_result_src;
    logic [DATA_WIDTH-1:0]    w_wb_read_data;
    logic [DATA_WIDTH-1:0]    w_wb_alu;
    logic [4:0]               w_wb_rd;
    logic [ADDRESS_WIDTH-1:0] w_wb_pc4;
    logic [BITS_THREADS-1:0]  w_wb_tid;
    logic                     w_misalign;
    logic                     w_bus_err;
    logic [BITS_THREADS-1:0]  w_err_tid;

    logic                     w_wait;
    logic                     w_is_mem;
    logic                     w_accept;
    logic                     w_timeout;
    logic [2:0]               w_la_funct3;
    logic [1:0]               w_la_addr;
    logic [3:0]               w_la_be;
    logic [DATA_WIDTH-1:0]    w_la_wdata;
    logic [DATA_WIDTH-1:0]    w_la_rdata;
    logic                     w_la_mis;

    assign w_wait    = (r_state == LSU_WAIT);
    assign w_is_mem  = mem_write_m_i | (result_src_m_i == RESULT_SRC_LOAD);
    assign w_accept  = !w_wait && w_is_mem && !w_la_mis;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Aligner looks at the incoming op in IDLE (for misalignment) and the held op in WAIT
    assign w_la_funct3 = w_wait ? r_h_funct3 : funct3_m_i;
    assign w_la_addr   = w_wait ? r_h_alu[1:0] : alu_result_m_i[1:0];

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .i_funct3     (w_la_funct3),
        .i_addr       (w_la_addr),
        .i_wdata      (r_h_wdata),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_la_be),
        .o_wdata      (w_la_wdata),
        .o_rdata_ext  (w_la_rdata),
        .o_misaligned (w_la_mis)
    );

    // FSM state and timeout counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next state; ack wins over timeout on the same cycle
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) w_state_next = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (dmem_ack_i || w_timeout) w_state_next = LSU_IDLE;
                else                         w_cnt_next   = r_cnt + CNT_W'(1);
            end
            default: w_state_next = LSU_IDLE;
        endcase
    end

    // FSM outputs: stall and bus signals, bus fields quiet outside WAIT
    always_comb begin
        stall_m_o    = w_wait;
        dmem_req_o   = w_wait;
        dmem_we_o    = w_wait & r_h_we;
        dmem_addr_o  = w_wait ? {r_h_alu[ADDRESS_WIDTH-1:2], 2'b00} : '0;
        dmem_be_o    = w_wait ? w_la_be : 4'b0000;
        dmem_wdata_o = w_wait ? w_la_wdata : '0;
    end

    // Capture the op when a bus access is launched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_we         <= 1'b0;
            r_h_funct3     <= '0;
            r_h_alu        <= '0;
            r_h_wdata      <= '0;
            r_h_reg_write  <= 1'b0;
            r_h_result_src <= '0;
            r_h_rd         <= '0;
            r_h_pc4        <= '0;
            r_h_tid        <= '0;
        end else if (w_accept) begin
            r_h_we         <= mem_write_m_i;
            r_h_funct3     <= funct3_m_i;
            r_h_alu        <= alu_result_m_i;
            r_h_wdata      <= write_data_m_i;
            r_h_reg_write  <= reg_write_m_i;
            r_h_result_src <= result_src_m_i;
            r_h_rd         <= rd_m_i;
            r_h_pc4        <= pc_plus4_m_i;
            r_h_tid        <= tid_m_i;
        end
    end

    // MEM/WB next values; every cycle is a bubble unless an op completes
    always_comb begin
        w_wb_reg_write  = 1'b0;
        w_wb_result_src = w_wait ? r_h_result_src : result_src_m_i;
        w_wb_read_data  = '0;
        w_wb_alu        = w_wait ? r_h_alu : alu_result_m_i;
        w_wb_rd         = w_wait ? r_h_rd : rd_m_i;
        w_wb_pc4        = w_wait ? r_h_pc4 : pc_plus4_m_i;
        w_wb_tid        = w_wait ? r_h_tid : tid_m_i;
        w_misalign      = 1'b0;
        w_bus_err       = 1'b0;
        w_err_tid       = '0;
        case (r_state)
            LSU_IDLE: begin
                if (!w_is_mem) begin
                    w_wb_reg_write = reg_write_m_i;
                end else if (w_la_mis) begin
                    w_misalign = 1'b1;
                    w_err_tid  = tid_m_i;
                end
            end
            LSU_WAIT: begin
                if (dmem_ack_i) begin
                    if (!r_h_we) begin
                        w_wb_reg_write = r_h_reg_write;
                        w_wb_read_data = w_la_rdata;
                    end
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                    w_err_tid = r_h_tid;
                end
            end
            default: ;
        endcase
    end

    // MEM/WB output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_w_o  <= 1'b0;
            result_src_w_o <= '0;
            read_data_w_o  <= '0;
            alu_result_w_o <= '0;
            rd_w_o         <= '0;
            pc_plus4_w_o   <= '0;
            tid_w_o        <= '0;
            misalign_o     <= 1'b0;
            bus_err_o      <= 1'b0;
            err_tid_o      <= '0;
        end else begin
            reg_write_w_o  <= w_wb_reg_write;
            result_src_w_o <= w_wb_result_src;
            read_data_w_o  <= w_wb_read_data;
            alu_result_w_o <= w_wb_alu;
            rd_w_o         <= w_wb_rd;
            pc_plus4_w_o   <= w_wb_pc4;
            tid_w_o        <= w_wb_tid;
            misalign_o     <= w_misalign;
            bus_err_o      <= w_bus_err;
            err_tid_o      <= w_err_tid;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single-cycle ops plus bus sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        reg_write_m_i;
    logic        mem_write_m_i;
    logic [1:0]  result_src_m_i;
    logic [2:0]  funct3_m_i;
    logic [31:0] alu_result_m_i;
    logic [31:0] write_data_m_i;
    logic [4:0]  rd_m_i;
    logic [31:0] pc_plus4_m_i;
    logic [2:0]  tid_m_i;
    logic        stall_m_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        reg_write_w_o;
    logic [1:0]  result_src_w_o;
    logic [31:0] read_data_w_o;
    logic [31:0] alu_result_w_o;
    logic [4:0]  rd_w_o;
    logic [31:0] pc_plus4_w_o;
    logic [2:0]  tid_w_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic [2:0]  err_tid_o;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .BITS_THREADS   (3),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_write_m_i  (reg_write_m_i),
        .mem_write_m_i  (mem_write_m_i),
        .result_src_m_i (result_src_m_i),
        .funct3_m_i     (funct3_m_i),
        .alu_result_m_i (alu_result_m_i),
        .write_data_m_i (write_data_m_i),
        .rd_m_i         (rd_m_i),
        .pc_plus4_m_i   (pc_plus4_m_i),
        .tid_m_i        (tid_m_i),
        .stall_m_o      (stall_m_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .reg_write_w_o  (reg_write_w_o),
        .result_src_w_o (result_src_w_o),
        .read_data_w_o  (read_data_w_o),
        .alu_result_w_o (alu_result_w_o),
        .rd_w_o         (rd_w_o),
        .pc_plus4_w_o   (pc_plus4_w_o),
        .tid_w_o        (tid_w_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o),
        .err_tid_o      (err_tid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [2:0]  tid;
        logic [31:0] pc4;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic rw, input logic mw, input logic [1:0] src,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4, input logic [2:0] tid);
        reg_write_m_i  = rw;
        mem_write_m_i  = mw;
        result_src_m_i = src;
        funct3_m_i     = f3;
        alu_result_m_i = alu;
        write_data_m_i = wd;
        rd_m_i         = rd;
        pc_plus4_m_i   = pc4;
        tid_m_i        = tid;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 3'd0);
    endtask

    // Entered just after a rising edge; ack arrives on WAIT cycle n_wait (0-based)
    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input int n_wait);
        set_op(1'b0, 1'b1, 2'b00, f3, addr, data, 5'd0, 32'h0, 3'd1);
        @(posedge clk); #1;
        for (int k = 0; k <= n_wait; k++) begin
            chk({nm, "_stall"}, 32'(stall_m_o), 32'd1);
            chk({nm, "_req"}, 32'(dmem_req_o), 32'd1);
            chk({nm, "_we"}, 32'(dmem_we_o), 32'd1);
            chk({nm, "_addr"}, dmem_addr_o, exp_addr);
            chk({nm, "_be"}, 32'(dmem_be_o), 32'(exp_be));
            chk({nm, "_wdata"}, dmem_wdata_o, exp_wd);
            chk({nm, "_wb_bubble"}, 32'(reg_write_w_o), 32'd0);
            if (k == n_wait) dmem_ack_i = 1'b1;
            @(posedge clk); #1;
            dmem_ack_i = 1'b0;
        end
        chk({nm, "_stall_done"}, 32'(stall_m_o), 32'd0);
        chk({nm, "_req_done"}, 32'(dmem_req_o), 32'd0);
        chk({nm, "_no_wb"}, 32'(reg_write_w_o), 32'd0);
        chk({nm, "_no_buserr"}, 32'(bus_err_o), 32'd0);
        nop();
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [2:0] tid, input logic [3:0] exp_be,
                           input logic [31:0] exp_data, input int n_wait);
        set_op(1'b1, 1'b0, 2'b01, f3, addr, 32'h0, rd, 32'h0, tid);
        @(posedge clk); #1;
        for (int k = 0; k <= n_wait; k++) begin
            chk({nm, "_stall"}, 32'(stall_m_o), 32'd1);
            chk({nm, "_req"}, 32'(dmem_req_o), 32'd1);
            chk({nm, "_we"}, 32'(dmem_we_o), 32'd0);
            chk({nm, "_be"}, 32'(dmem_be_o), 32'(exp_be));
            chk({nm, "_wb_bubble"}, 32'(reg_write_w_o), 32'd0);
            if (k == n_wait) begin
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = rdata;
            end
            @(posedge clk); #1;
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = 32'h5A5A_5A5A;
        end
        chk({nm, "_rw"}, 32'(reg_write_w_o), 32'd1);
        chk({nm, "_data"}, read_data_w_o, exp_data);
        chk({nm, "_rd"}, 32'(rd_w_o), 32'(rd));
        chk({nm, "_tid"}, 32'(tid_w_o), 32'(tid));
        chk({nm, "_src"}, 32'(result_src_w_o), 32'd1);
        chk({nm, "_stall_done"}, 32'(stall_m_o), 32'd0);
        nop();
    endtask

    initial begin
        //           rw    mw    src    f3      alu           rd     tid   pc4        erw  emis
        vecs[0] = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_1234, 5'd5,  3'd3, 32'h0000_0040, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_0077, 5'd1,  3'd7, 32'h0000_0200, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 3'b111, 32'hDEAD_BEEF, 5'd9,  3'd1, 32'h0000_0010, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0101, 5'd4,  3'd2, 32'h0000_0020, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 2'b01, 3'b001, 32'h0000_0103, 5'd6,  3'd4, 32'h0000_0024, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 2'b00, 3'b010, 32'h0000_0102, 5'd0,  3'd5, 32'h0000_0028, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 2'b01, 3'b011, 32'h0000_0100, 5'd3,  3'd6, 32'h0000_002C, 1'b0, 1'b1};

        rst_n        = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_m_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_rw", 32'(reg_write_w_o), 32'd0);
        chk("rst_rdata", read_data_w_o, 32'd0);
        chk("rst_alu", alu_result_w_o, 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_berr", 32'(bus_err_o), 32'd0);
        chk("rst_etid", 32'(err_tid_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops: pass-through and dropped misaligned accesses
        for (int i = 0; i < 7; i++) begin
            set_op(vecs[i].rw, vecs[i].mw, vecs[i].src, vecs[i].f3, vecs[i].alu, 32'h0,
                   vecs[i].rd, vecs[i].pc4, vecs[i].tid);
            @(negedge clk);
            chk("vec_stall", 32'(stall_m_o), 32'd0);
            chk("vec_req", 32'(dmem_req_o), 32'd0);
            @(posedge clk); #1;
            chk("vec_rw", 32'(reg_write_w_o), 32'(vecs[i].exp_rw));
            chk("vec_mis", 32'(misalign_o), 32'(vecs[i].exp_mis));
            chk("vec_rdata", read_data_w_o, 32'd0);
            chk("vec_stall_after", 32'(stall_m_o), 32'd0);
            if (vecs[i].exp_mis) chk("vec_err_tid", 32'(err_tid_o), 32'(vecs[i].tid));
            if (vecs[i].exp_rw) begin
                chk("vec_alu", alu_result_w_o, vecs[i].alu);
                chk("vec_rd", 32'(rd_w_o), 32'(vecs[i].rd));
                chk("vec_tid", 32'(tid_w_o), 32'(vecs[i].tid));
                chk("vec_src", 32'(result_src_w_o), 32'(vecs[i].src));
                chk("vec_pc4", pc_plus4_w_o, vecs[i].pc4);
            end
        end
        nop();
        @(posedge clk); #1;
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);

        // Stores; SB acks on the counter's last value so ack must beat timeout
        do_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0100, 4'b1000,
                 32'hABAB_ABAB, 3);
        do_store("sh", 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0000_0200, 4'b1100,
                 32'hBEEF_BEEF, 0);
        do_store("sw", 3'b010, 32'h0000_0204, 32'h1122_3344, 32'h0000_0204, 4'b1111,
                 32'h1122_3344, 1);

        // Loads with lane alignment and extension
        do_load("lh",  3'b001, 32'h0000_0102, 32'h8001_1234, 5'd9,  3'd4, 4'b1100,
                32'hFFFF_8001, 0);
        do_load("lhu", 3'b101, 32'h0000_0102, 32'h8001_1234, 5'd10, 3'd5, 4'b1100,
                32'h0000_8001, 1);
        do_load("lb",  3'b000, 32'h0000_0101, 32'h0000_9A00, 5'd11, 3'd6, 4'b0010,
                32'hFFFF_FF9A, 0);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h7F00_0000, 5'd12, 3'd7, 4'b1000,
                32'h0000_007F, 0);
        do_load("lw",  3'b010, 32'h0000_0104, 32'hCAFE_F00D, 5'd13, 3'd1, 4'b1111,
                32'hCAFE_F00D, 2);
        do_load("lw_x0", 3'b010, 32'h0000_0108, 32'h0BAD_CAFE, 5'd0, 3'd2, 4'b1111,
                32'h0BAD_CAFE, 0);

        // Never-acked load times out after 4 WAIT cycles
        set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0200, 32'h0, 5'd7, 32'h0, 3'd6);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk("to_stall", 32'(stall_m_o), 32'd1);
            chk("to_berr_early", 32'(bus_err_o), 32'd0);
            @(posedge clk); #1;
        end
        chk("to_berr", 32'(bus_err_o), 32'd1);
        chk("to_etid", 32'(err_tid_o), 32'd6);
        chk("to_rw", 32'(reg_write_w_o), 32'd0);
        chk("to_stall_done", 32'(stall_m_o), 32'd0);
        set_op(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_4321, 32'h0, 5'd8, 32'h0, 3'd3);
        @(posedge clk); #1;
        chk("to_berr_pulse", 32'(bus_err_o), 32'd0);
        chk("to_next_rw", 32'(reg_write_w_o), 32'd1);
        chk("to_next_alu", alu_result_w_o, 32'h0000_4321);
        nop();

        // Reset while WAIT abandons the access; a late ack is ignored
        set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0300, 32'h0, 5'd15, 32'h0, 3'd5);
        @(posedge clk); #1;
        chk("rw_wait_req", 32'(dmem_req_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rw_req", 32'(dmem_req_o), 32'd0);
        chk("rw_stall", 32'(stall_m_o), 32'd0);
        chk("rw_rw", 32'(reg_write_w_o), 32'd0);
        rst_n = 1'b1;
        nop();
        @(posedge clk); #1;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        chk("rw_late_rw", 32'(reg_write_w_o), 32'd0);
        chk("rw_late_data", read_data_w_o, 32'd0);
        chk("rw_late_req", 32'(dmem_req_o), 32'd0);
        chk("rw_late_stall", 32'(stall_m_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
